// File: rtl/glyph_blitter.sv
// Copies a GLYPH_W x GLYPH_H digit glyph from the glyph store into the framebuffer, clipping at the edges.
// Optional macro GLYPH_BLITTER_TRANSPARENT_EN: zero-valued glyph pixels are skipped so the background shows through.
module glyph_blitter #(
    parameter int LEN      = 14800,
    parameter int WIDTH    = 4,
    parameter int X_MAX    = 160,
    parameter int Y_MAX    = 80,
    parameter int GLYPH_W  = 10,
    parameter int GLYPH_H  = 20,
    parameter int SRC_BASE = X_MAX * Y_MAX
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [3:0]              digit,
    input  logic [7:0]              pos_x,
    input  logic [6:0]              pos_y,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(LEN)-1:0]  addr,
    output logic [WIDTH-1:0]        din,
    input  logic [WIDTH-1:0]        dout,
    output logic                    we
);

    localparam int AW  = $clog2(LEN);
    localparam int GXW = $clog2(GLYPH_W + 1);
    localparam int GYW = $clog2(GLYPH_H + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t           state_r;
    logic [3:0]       digit_r;
    logic [7:0]       pos_x_r;
    logic [6:0]       pos_y_r;
    logic [GXW-1:0]   gx_r;
    logic [GYW-1:0]   gy_r;
    logic [AW-1:0]    addr_r;
    logic             we_r;
    logic             busy_r;
    logic             done_r;
    logic             blank_r;

    // Address math is done at 32 bits and only narrowed at the very end.
    function automatic logic [AW-1:0] src_addr(input logic [3:0] d,
                                               input logic [GXW-1:0] x,
                                               input logic [GYW-1:0] y);
        logic [31:0] a;
        a = 32'(SRC_BASE) + 32'(d) * 32'(GLYPH_W * GLYPH_H) + 32'(y) * 32'(GLYPH_W) + 32'(x);
        return a[AW-1:0];
    endfunction

    function automatic logic [AW-1:0] dst_addr(input logic [7:0] px,
                                               input logic [6:0] py,
                                               input logic [GXW-1:0] x,
                                               input logic [GYW-1:0] y);
        logic [31:0] a;
        a = (32'(py) + 32'(y)) * 32'(X_MAX) + 32'(px) + 32'(x);
        return a[AW-1:0];
    endfunction

    function automatic logic clipped(input logic [7:0] px,
                                     input logic [6:0] py,
                                     input logic [GXW-1:0] x,
                                     input logic [GYW-1:0] y);
        logic [31:0] cx;
        logic [31:0] cy;
        cx = 32'(px) + 32'(x);
        cy = 32'(py) + 32'(y);
        return (cx >= 32'(X_MAX)) || (cy >= 32'(Y_MAX));
    endfunction

    // Blit sequencer: each glyph pixel costs one READ and one WRITE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            digit_r <= 4'd0;
            pos_x_r <= 8'd0;
            pos_y_r <= 7'd0;
            gx_r    <= '0;
            gy_r    <= '0;
            addr_r  <= '0;
            we_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            blank_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    we_r   <= 1'b0;
                    done_r <= 1'b0;
                    if (start) begin
                        digit_r <= digit;
                        pos_x_r <= pos_x;
                        pos_y_r <= pos_y;
                        blank_r <= (digit > 4'd9);
                        gx_r    <= '0;
                        gy_r    <= '0;
                        busy_r  <= 1'b1;
                        addr_r  <= src_addr(digit, GXW'(0), GYW'(0));
                        state_r <= READ;
                    end else begin
                        busy_r  <= 1'b0;
                        addr_r  <= '0;
                    end
                end
                READ: begin
                    addr_r  <= dst_addr(pos_x_r, pos_y_r, gx_r, gy_r);
                    we_r    <= !clipped(pos_x_r, pos_y_r, gx_r, gy_r);
                    state_r <= WRITE;
                end
                WRITE: begin
                    we_r <= 1'b0;
                    if (gx_r == GXW'(GLYPH_W - 1)) begin
                        gx_r <= '0;
                        if (gy_r == GYW'(GLYPH_H - 1)) begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            addr_r  <= '0;
                            state_r <= FIN;
                        end else begin
                            gy_r    <= gy_r + GYW'(1);
                            addr_r  <= src_addr(digit_r, GXW'(0), gy_r + GYW'(1));
                            state_r <= READ;
                        end
                    end else begin
                        gx_r    <= gx_r + GXW'(1);
                        addr_r  <= src_addr(digit_r, gx_r + GXW'(1), gy_r);
                        state_r <= READ;
                    end
                end
                FIN: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    we_r    <= 1'b0;
                    addr_r  <= '0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    we_r    <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    addr_r  <= '0;
                end
            endcase
        end
    end

    // Read data only arrives during WRITE, so write data is a gated pass-through of dout.
    assign din  = ((state_r == WRITE) && !blank_r) ? dout : '0;
    assign addr = addr_r;
    assign busy = busy_r;
    assign done = done_r;

`ifdef GLYPH_BLITTER_TRANSPARENT_EN
    assign we = we_r & (dout != '0);
`else
    assign we = we_r;
`endif

endmodule
